// File: rtl/fifo_pkg.sv
// Default geometry shared by the synchronous FIFO and its storage array.
package fifo_pkg;

    // Width of one stored word.
    localparam int FIFO_DATA_WIDTH = 8;

    // Pointer width; the FIFO holds 2**FIFO_ADDR_WIDTH words.
    localparam int FIFO_ADDR_WIDTH = 3;

    // Number of entries implied by the pointer width.
    localparam int FIFO_DEFAULT_DEPTH = 1 << FIFO_ADDR_WIDTH;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: one write port and one registered
// read port. Contents are never cleared; only the read register resets so the
// FIFO output starts from a known zero.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Write port: storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value whenever no read is requested.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule : fifo_mem

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO used as a rate-decoupling buffer. Pointers, occupancy
// count and status flags live here; the words themselves live in fifo_mem.
// Writes while full and reads while empty are silently dropped.
module sync_fifo_top
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_we,
    input  logic                  i_rd,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  fifo_full,
    output logic                  fifo_empty
);

    // Depth expressed at the width of the count register.
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  we_ok;
    logic                  rd_ok;

    // Flags decode directly from the occupancy count.
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);

    // Requests are only honoured when there is room / something to read.
    assign we_ok = i_we & ~fifo_full;
    assign rd_ok = i_rd & ~fifo_empty;

    // Occupancy changes only when exactly one side is accepted.
    always_comb begin
        count_next = count;
        unique case ({we_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer and count state; the pointers wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (we_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Storage array with the registered read data that drives o_data.
    // Read and write never collide on one address: a read of the slot being
    // written could only happen when full or empty, and one side is then
    // blocked, so there is no write-to-read bypass to worry about.
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we_ok),
        .waddr (wptr),
        .wdata (i_data),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (o_data)
    );

endmodule : sync_fifo_top

// File: tb/tb_sync_fifo_top.sv
// Self-checking bench for sync_fifo_top: a scoreboard queue receives every
// word the model says will be accepted, and each accepted read pops and
// compares. Occupancy flags and pointers are checked against the model.
module tb_sync_fifo_top;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_we = 1'b0;
    logic       i_rd = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [7:0] o_data;
    logic       fifo_full;
    logic       fifo_empty;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb [$];
    int         m_cnt  = 0;
    int         m_wp   = 0;
    int         m_rp   = 0;
    logic [7:0] m_last = 8'h00;

    sync_fifo_top uut (
        .clk        (clk),
        .rstn       (rstn),
        .i_we       (i_we),
        .i_rd       (i_rd),
        .i_data     (i_data),
        .o_data     (o_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; model decides acceptance, DUT checked 1ns after the edge.
    task automatic step(input logic we, input logic rd, input logic [7:0] d);
        logic wok;
        logic rok;
        @(negedge clk);
        i_we   = we;
        i_rd   = rd;
        i_data = d;
        wok = we && (m_cnt != 8);
        rok = rd && (m_cnt != 0);
        if (wok) sb.push_back(d);
        @(posedge clk);
        #1;
        if (rok) begin
            m_last = sb.pop_front();
            m_rp   = (m_rp + 1) % 8;
            m_cnt  = m_cnt - 1;
        end
        if (wok) begin
            m_wp  = (m_wp + 1) % 8;
            m_cnt = m_cnt + 1;
        end
        $display("txn we=%0b rd=%0b din=%02h -> acc_w=%0b acc_r=%0b dout=%02h full=%0b empty=%0b",
                 we, rd, d, wok, rok, o_data, fifo_full, fifo_empty);
        check("o_data", {24'h0, o_data}, {24'h0, m_last});
        check("fifo_full", {31'h0, fifo_full}, (m_cnt == 8) ? 32'd1 : 32'd0);
        check("fifo_empty", {31'h0, fifo_empty}, (m_cnt == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic check_ptrs(input string tag);
        check({tag, "_wptr"}, {29'h0, uut.wptr}, m_wp);
        check({tag, "_rptr"}, {29'h0, uut.rptr}, m_rp);
        check({tag, "_count"}, {28'h0, uut.count}, m_cnt);
    endtask

    // Reset for one edge with a write request pending; the write must be lost.
    task automatic do_reset();
        @(negedge clk);
        rstn   = 1'b0;
        i_we   = 1'b1;
        i_rd   = 1'b0;
        i_data = 8'hEE;
        @(posedge clk);
        #1;
        sb.delete();
        m_cnt  = 0;
        m_wp   = 0;
        m_rp   = 0;
        m_last = 8'h00;
        $display("txn reset -> dout=%02h full=%0b empty=%0b", o_data, fifo_full, fifo_empty);
        check("rst_o_data", {24'h0, o_data}, 32'h0);
        check("rst_empty", {31'h0, fifo_empty}, 32'd1);
        check("rst_full", {31'h0, fifo_full}, 32'd0);
        check_ptrs("rst");
        @(negedge clk);
        rstn = 1'b1;
        i_we = 1'b0;
    endtask

    logic [7:0] fill_data [10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D,
                                   8'h8D, 8'h65, 8'h12, 8'hAA, 8'hBB};

    initial begin
        do_reset();
        step(1'b0, 1'b0, 8'h00);

        // Fill past capacity: last two writes dropped, write pointer wraps.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, fill_data[i]);
        check("fill_wptr_wrap", {29'h0, uut.wptr}, 32'd0);
        check_ptrs("fill");

        // Drain past empty: ninth read ignored, o_data holds 0x12.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00);
        check("drain_hold", {24'h0, o_data}, 32'h12);
        check_ptrs("drain");

        // Mid-level simultaneous traffic with three words stored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'hC0 + 8'(i));
        check_ptrs("simul");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
        check_ptrs("simul_drain");

        // Full with both requests: only the read happens.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h50 + 8'(i));
        step(1'b1, 1'b1, 8'hFE);
        check_ptrs("full_both");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);

        // Empty with both requests: only the write happens, o_data unchanged.
        step(1'b1, 1'b1, 8'h77);
        check_ptrs("empty_both");
        step(1'b0, 1'b1, 8'h00);

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
        do_reset();
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_word", {24'h0, o_data}, 32'h5A);
        step(1'b0, 1'b1, 8'h00);
        check_ptrs("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sync_fifo_top
